// File: rtl/mau_pkg.sv
// -----------------------------------------------------------------------------
// mau_pkg
// Shared definitions for the memory access unit:
//   - FSM state encodings (IDLE, REQ, RESP)
//   - ld_mode / st_mode operation codes
//   - access-size codes and helpers that decode size and detect misalignment
// -----------------------------------------------------------------------------
package mau_pkg;

    // FSM state encodings
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    // Load mode codes
    localparam logic [2:0] LDM_LW  = 3'b000;
    localparam logic [2:0] LDM_LB  = 3'b001;
    localparam logic [2:0] LDM_LBU = 3'b010;
    localparam logic [2:0] LDM_LH  = 3'b011;
    localparam logic [2:0] LDM_LHU = 3'b100;

    // Store mode codes
    localparam logic [2:0] STM_SW  = 3'b000;
    localparam logic [2:0] STM_SB  = 3'b010;
    localparam logic [2:0] STM_SH  = 3'b100;

    // Access size codes
    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    // Size of a load; unknown codes behave as a word load
    function automatic logic [1:0] ld_size(input logic [2:0] mode);
        logic [1:0] sz;
        case (mode)
            LDM_LB, LDM_LBU: sz = SZ_BYTE;
            LDM_LH, LDM_LHU: sz = SZ_HALF;
            default:         sz = SZ_WORD;
        endcase
        return sz;
    endfunction

    // Size of a store; unknown codes behave as a word store
    function automatic logic [1:0] st_size(input logic [2:0] mode);
        logic [1:0] sz;
        case (mode)
            STM_SB:  sz = SZ_BYTE;
            STM_SH:  sz = SZ_HALF;
            default: sz = SZ_WORD;
        endcase
        return sz;
    endfunction

    // Halfwords need addr[0]=0, words need addr[1:0]=0, bytes always fit
    function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] lo);
        logic mis;
        case (sz)
            SZ_BYTE: mis = 1'b0;
            SZ_HALF: mis = lo[0];
            default: mis = (lo != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_access_unit_load_extender.sv
// -----------------------------------------------------------------------------
// load_extender
// Combinational lane select and sign/zero extension of a load response.
// Ports:
//   dm_rdata [31:0] in  : raw word returned by data memory
//   addr_lo  [1:0]  in  : low address bits of the access (byte lane)
//   ld_mode  [2:0]  in  : load mode code (LB/LH/LW/LBU/LHU, others as LW)
//   result   [31:0] out : extended load value
// -----------------------------------------------------------------------------
module load_extender
    import mau_pkg::*;
(
    input  logic [31:0] dm_rdata,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  ld_mode,
    output logic [31:0] result
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Pick the addressed byte lane and halfword lane
    always_comb begin
        byte_s = 8'h00;
        half_s = 16'h0000;
        case (addr_lo)
            2'd0:    byte_s = dm_rdata[7:0];
            2'd1:    byte_s = dm_rdata[15:8];
            2'd2:    byte_s = dm_rdata[23:16];
            2'd3:    byte_s = dm_rdata[31:24];
            default: byte_s = dm_rdata[7:0];
        endcase
        if (addr_lo[1]) begin
            half_s = dm_rdata[31:16];
        end else begin
            half_s = dm_rdata[15:0];
        end
    end

    // Extend the selected lane according to the load mode
    always_comb begin
        result = 32'h0000_0000;
        case (ld_mode)
            LDM_LB:  result = {{24{byte_s[7]}}, byte_s};
            LDM_LBU: result = {24'h00_0000, byte_s};
            LDM_LH:  result = {{16{half_s[15]}}, half_s};
            LDM_LHU: result = {16'h0000, half_s};
            default: result = dm_rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
// Memory-stage load/store unit. Accepts one operation in IDLE, issues a single
// request to data memory (REQ), and reports completion for one cycle (RESP).
// Misaligned accesses skip the memory request and complete with mis_align.
//
// Build option: define MAU_TIMEOUT_EN to abort a request that is not
// acknowledged within TIMEOUT_CYC cycles (completes with bus_err=1).
//
// Ports:
//   clk, rstn                 : clock, asynchronous active-low reset
//   op_valid, mem_read,
//   mem_write                 : operation present, load / store select
//   ld_mode, st_mode [2:0]    : load / store width codes
//   addr, wdata [31:0]        : byte address and store data
//   stall                     : pipeline hold (combinational on acceptance)
//   done                      : one-cycle completion pulse
//   rdata [31:0]              : extended load result, valid with done
//   mis_align, bus_err        : error pulses coincident with done
//   dm_req, dm_we, dm_addr,
//   dm_wdata, dm_wstrb        : data-memory request (word aligned address)
//   dm_ack, dm_rdata          : data-memory response
// -----------------------------------------------------------------------------
module mem_access_unit
    import mau_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 255
)
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        op_valid,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  ld_mode,
    input  logic [2:0]  st_mode,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic        done,
    output logic [31:0] rdata,
    output logic        mis_align,
    output logic        bus_err,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    output logic [3:0]  dm_wstrb,
    input  logic        dm_ack,
    input  logic [31:0] dm_rdata
);

    logic [1:0]  state_r;
    logic        dm_req_r;
    logic        dm_we_r;
    logic [31:0] dm_addr_r;
    logic [31:0] dm_wdata_r;
    logic [3:0]  dm_wstrb_r;
    logic [2:0]  ld_mode_r;
    logic [1:0]  addr_lo_r;
    logic        done_r;
    logic        mis_align_r;
    logic [31:0] rdata_r;

    logic        accept_s;
    logic        is_store_s;
    logic [1:0]  size_s;
    logic        misalign_s;
    logic [3:0]  wstrb_s;
    logic [31:0] wdata_s;
    logic [31:0] ext_s;
    logic        timeout_s;

    // Decode the incoming operation; a simultaneous read+write is a store
    always_comb begin
        accept_s   = (state_r == ST_IDLE) & op_valid & (mem_read | mem_write);
        is_store_s = mem_write;
        if (is_store_s) begin
            size_s = st_size(st_mode);
        end else begin
            size_s = ld_size(ld_mode);
        end
        misalign_s = is_misaligned(size_s, addr[1:0]);
    end

    // Store byte strobes and lane-replicated store data
    always_comb begin
        wstrb_s = 4'b0000;
        wdata_s = 32'h0000_0000;
        if (is_store_s) begin
            case (size_s)
                SZ_BYTE: begin
                    wstrb_s = 4'b0001 << addr[1:0];
                    wdata_s = {4{wdata[7:0]}};
                end
                SZ_HALF: begin
                    wstrb_s = 4'b0011 << addr[1:0];
                    wdata_s = {2{wdata[15:0]}};
                end
                default: begin
                    wstrb_s = 4'b1111;
                    wdata_s = wdata;
                end
            endcase
        end else begin
            wstrb_s = 4'b0000;
            wdata_s = 32'h0000_0000;
        end
    end

    load_extender u_load_extender (
        .dm_rdata (dm_rdata),
        .addr_lo  (addr_lo_r),
        .ld_mode  (ld_mode_r),
        .result   (ext_s)
    );

`ifdef MAU_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cnt_r;
    logic             bus_err_r;

    // Count consecutive un-acknowledged REQ cycles; restart outside REQ
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_r <= '0;
        end else if ((state_r == ST_REQ) && !dm_ack) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r <= '0;
        end
    end

    assign timeout_s = (state_r == ST_REQ) & ~dm_ack & (cnt_r == CNT_LAST);

    // bus_err is high exactly in the RESP cycle that follows a timeout
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bus_err_r <= 1'b0;
        end else begin
            bus_err_r <= timeout_s;
        end
    end

    assign bus_err = bus_err_r;
`else
    assign timeout_s = 1'b0;
    assign bus_err   = 1'b0;
`endif

    // Main FSM with registered request and completion outputs
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r     <= ST_IDLE;
            dm_req_r    <= 1'b0;
            dm_we_r     <= 1'b0;
            dm_addr_r   <= 32'h0000_0000;
            dm_wdata_r  <= 32'h0000_0000;
            dm_wstrb_r  <= 4'b0000;
            ld_mode_r   <= 3'b000;
            addr_lo_r   <= 2'b00;
            done_r      <= 1'b0;
            mis_align_r <= 1'b0;
            rdata_r     <= 32'h0000_0000;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        ld_mode_r  <= ld_mode;
                        addr_lo_r  <= addr[1:0];
                        dm_addr_r  <= {addr[31:2], 2'b00};
                        dm_wdata_r <= wdata_s;
                        if (misalign_s) begin
                            // No memory traffic: report the fault straight away
                            state_r     <= ST_RESP;
                            dm_we_r     <= 1'b0;
                            dm_wstrb_r  <= 4'b0000;
                            done_r      <= 1'b1;
                            mis_align_r <= 1'b1;
                            rdata_r     <= 32'h0000_0000;
                        end else begin
                            state_r    <= ST_REQ;
                            dm_req_r   <= 1'b1;
                            dm_we_r    <= is_store_s;
                            dm_wstrb_r <= wstrb_s;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_REQ: begin
                    if (dm_ack) begin
                        state_r  <= ST_RESP;
                        dm_req_r <= 1'b0;
                        dm_we_r  <= 1'b0;
                        done_r   <= 1'b1;
                        if (dm_we_r) begin
                            rdata_r <= 32'h0000_0000;
                        end else begin
                            rdata_r <= ext_s;
                        end
                    end else if (timeout_s) begin
                        state_r  <= ST_RESP;
                        dm_req_r <= 1'b0;
                        dm_we_r  <= 1'b0;
                        done_r   <= 1'b1;
                        rdata_r  <= 32'h0000_0000;
                    end else begin
                        state_r <= ST_REQ;
                    end
                end
                ST_RESP: begin
                    state_r     <= ST_IDLE;
                    done_r      <= 1'b0;
                    mis_align_r <= 1'b0;
                end
                default: begin
                    state_r     <= ST_IDLE;
                    dm_req_r    <= 1'b0;
                    dm_we_r     <= 1'b0;
                    done_r      <= 1'b0;
                    mis_align_r <= 1'b0;
                end
            endcase
        end
    end

    // Hold is needed while accepting and while waiting for memory
    assign stall     = accept_s | (state_r == ST_REQ);
    assign done      = done_r;
    assign rdata     = rdata_r;
    assign mis_align = mis_align_r;
    assign dm_req    = dm_req_r;
    assign dm_we     = dm_we_r;
    assign dm_addr   = dm_addr_r;
    assign dm_wdata  = dm_wdata_r;
    assign dm_wstrb  = dm_wstrb_r;

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYC, default 255, the maximum wait cycles for dm_ack (used only under MAU_TIMEOUT_EN).
REQ-002 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-003 The block SHALL have port clk, input, 1 bit: rising-edge clock for all state.
REQ-004 The block SHALL have port rstn, input, 1 bit: asynchronous active-low reset.
REQ-005 The block SHALL have port op_valid, input, 1 bit: the memory-stage operation is present.
REQ-006 The block SHALL have ports mem_read and mem_write, input, 1 bit each: load and store select.
REQ-007 The block SHALL have port ld_mode, input, 3 bits: 001 LB, 011 LH, 000 LW, 010 LBU, 100 LHU.
REQ-008 The block SHALL have port st_mode, input, 3 bits: 010 SB, 100 SH, 000 SW.
REQ-009 The block SHALL have ports addr and wdata, input, 32 bits each: byte address and store data.
REQ-010 The block SHALL have port stall, output, 1 bit: the pipeline must hold.
REQ-011 The block SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-012 The block SHALL have port rdata, output, 32 bits: extended load result, valid with done.
REQ-013 The block SHALL have port mis_align, output, 1 bit: misaligned-access pulse, coincident with done.
REQ-014 The block SHALL have port bus_err, output, 1 bit: timeout pulse, coincident with done.
REQ-015 The block SHALL have ports dm_req, dm_we, dm_addr[31:0], dm_wdata[31:0] and dm_wstrb[3:0], output: data-memory request; dm_addr[1:0] = 0.
REQ-016 The block SHALL have ports dm_ack (1 bit) and dm_rdata (32 bits), input: memory response.

Function
REQ-017 The FSM SHALL have states IDLE, REQ and RESP.
REQ-018 In IDLE with op_valid and (mem_read or mem_write), the block SHALL latch all inputs and move to REQ; stall SHALL be high combinationally in that same cycle.
REQ-019 If mem_read and mem_write are both high, the access SHALL be a store.
REQ-020 In REQ, dm_req SHALL stay high with stable outputs until dm_ack is sampled high, then the FSM SHALL move to RESP.
REQ-021 dm_ack sampled high in the first REQ cycle SHALL be accepted; a response of one cycle is legal.
REQ-022 dm_ack in IDLE or RESP SHALL be ignored.
REQ-023 RESP SHALL last one cycle: done=1, stall=0, rdata registered, then IDLE.
REQ-024 Minimum latency from acceptance to done SHALL be 2 cycles.
REQ-025 A new op in the cycle after done SHALL be accepted normally.
REQ-026 Loads SHALL select the byte by addr[1:0] and the halfword by addr[1]; LB and LH SHALL sign-extend, and LBU and LHU SHALL zero-extend.
REQ-027 Stores SHALL set dm_wstrb to 0001<<addr[1:0] (SB), 0011<<addr[1:0] (SH), or 1111 (SW).
REQ-028 Stores SHALL set dm_wdata to the byte or halfword replicated across lanes; dm_we=1.
REQ-029 Unlisted ld_mode codes SHALL be treated as LW; unlisted st_mode codes SHALL be treated as SW.
REQ-030 A misaligned access (half with addr[0]=1, word with addr[1:0]!=0) SHALL issue no dm_req, SHALL go IDLE->RESP directly, and SHALL raise done with mis_align=1 and rdata=0.
REQ-031 When op_valid=0, or neither mem_read nor mem_write is set, the block SHALL keep stall=0 and produce no activity.

Reset
REQ-032 Asserting rstn low SHALL immediately force IDLE with stall, done, dm_req, dm_we, mis_align and bus_err all 0, and rdata, dm_addr, dm_wdata and dm_wstrb all 0.
REQ-033 Reset asserted mid-REQ SHALL abort the access; a later dm_ack SHALL be ignored.

Configuration
REQ-034 With MAU_TIMEOUT_EN defined, a counter SHALL run in REQ; if dm_ack is absent for TIMEOUT_CYC cycles, the FSM SHALL drop dm_req and go to RESP with bus_err=1 and rdata=0.
REQ-035 Without MAU_TIMEOUT_EN, there SHALL be no counter, bus_err SHALL be tied 0, and REQ SHALL wait indefinitely.

Structure
REQ-036 Package mau_pkg SHALL hold the state enum and the ld_mode and st_mode code constants.
REQ-037 Sub-module load_extender SHALL hold the combinational lane select and extension (dm_rdata, addr[1:0], ld_mode -> 32-bit result).

Verification
REQ-038 The bench SHALL cover LB at addr 0x103 with dm_rdata 0x80_00_00_00 and ack after 1 cycle, requiring rdata 0xFFFFFF80 and done 2 cycles after acceptance.
REQ-039 The bench SHALL cover SH at addr 0x202 with wdata 0x0000BEEF, requiring dm_wstrb 1100, dm_wdata 0xBEEFBEEF, dm_addr 0x200 and dm_we=1.
REQ-040 The bench SHALL cover LW at addr 0x005, requiring no dm_req, done plus mis_align 1 cycle after acceptance, and rdata 0.
REQ-041 The bench SHALL cover LHU at 0x002 with ack delayed 5 cycles and dm_rdata 0x9ABC1234, requiring stall high for 6 cycles and rdata 0x00009ABC.
REQ-042 The bench SHALL cover rstn pulsed low during REQ followed by a late dm_ack, requiring dm_req to fall asynchronously and no done.
REQ-043 With MAU_TIMEOUT_EN and TIMEOUT_CYC=4, the bench SHALL cover a request that is never acked, requiring bus_err and done together, with dm_req deasserted after 4 REQ cycles.
